ec_seq_counter: RTL and testbench
=================================

# ec_seq_counter

Parametrised successor to the single-mode 8-bit target counter in the EC lab series. It latches a target value `A` after reset release, steps `led` toward it at a programmable prescaled rate, and raises `H` on completion. It adds generic width, a prescaler, an enable/pause input, and four counting modes (up-halt, down-halt, up-wrap, ping-pong). It sits directly behind the board switches (`A`, `mode`) and drives the LED bank.

## Interface
- `WIDTH`, 8, width of `A` and `led`; legal range 2..32
- `PRESCALE`, 1, enabled clock cycles per count step; legal range 1..2^16
- `clk`  in  1  system clock; all logic is on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `A`  in  WIDTH  target value; sampled only in LOAD
- `mode`  in  2  count mode, sampled only in LOAD:
  - 00 UP_HALT
  - 01 DOWN_HALT
  - 10 UP_WRAP
  - 11 PING_PONG
- `en`  in  1  step enable; when low, the prescaler and `led` freeze
- `led`  out  WIDTH  current count value
- `H`  out  1  done flag; halt modes only; held until reset
- `wrap`  out  1  one-cycle pulse on each end-of-span turnaround (UP_WRAP, PING_PONG)
- `dir`  out  1  current direction, 1 = counting down

## Operation
- States: LOAD, RUN, HALT.
- **Reset high:**
  - state = LOAD
  - `led` = 0, `H` = 0, `wrap` = 0, `dir` = 0
  - prescaler = 0
  - latched target and mode = 0
- **LOAD:** the first rising edge with `Reset` low does all of the following:
  - latches `A` and `mode`
  - loads `led` = A for DOWN_HALT, else 0
  - sets `dir` = 1 for DOWN_HALT, else 0
  - clears the prescaler
  - goes to RUN
  - Exception: if the latched span is empty (A == 0) in a halt mode, it goes to HALT with `H` = 1 on that same edge.
- **RUN:** the prescaler increments on each cycle with `en` = 1. When it reaches PRESCALE-1 it returns to 0 and issues a step strobe. Each step does the following per mode:
  - UP_HALT: `led`+1. The step that makes `led` == A also sets `H` = 1 and moves to HALT.
  - DOWN_HALT: `led`-1. The step that makes `led` == 0 also sets `H` = 1 and moves to HALT.
  - UP_WRAP: if `led` == A, then `led` <= 0 and `wrap` pulses; else `led`+1.
  - PING_PONG:
    - Counting up and reaching `led` == A: flip `dir`, pulse `wrap`, then step down on later strobes.
    - Counting down and reaching 0: flip back to up and pulse `wrap`.
    - A == 0: `led` stays 0, and `wrap` pulses on every step.
- **HALT:** `led` and `H` hold. `en` is ignored. Only `Reset` leaves HALT.
- **Arithmetic:** unsigned, WIDTH bits. Overflow cannot occur in any mode because `led` never exceeds A. A = 2^WIDTH-1 is legal.
- Changes to `A` or `mode` after LOAD are ignored until the next reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Step latency:** with `en` held high, `led` changes every PRESCALE cycles. The first change comes PRESCALE cycles after the LOAD edge.
- `H` rises on the same edge on which `led` reaches its end value.
- `wrap` is high for exactly the one cycle following the turnaround step edge. It coincides with `led` showing the post-turnaround value.
- **en low mid-count:** the prescaler phase is kept, not cleared. Resuming continues the partial interval.
- **Reset mid-operation:** it takes priority over every other event on the same edge. All state returns to reset values, and the next low cycle performs LOAD.
- **Simultaneous step and turnaround:** a single edge performs both the value update and the flag/direction update. No bubble cycle is inserted.

## Structure
- Package `ec_pkg` holds:
  - `ec_mode_t`: the 2-bit enum UP_HALT / DOWN_HALT / UP_WRAP / PING_PONG
  - `ec_state_t`: the LOAD / RUN / HALT enum
- Sub-module `ec_prescaler`, which has:
  - parameter `PRESCALE`
  - inputs `clk`, `Reset`, `en`, `clr`
  - output `step` (one-cycle strobe)
  - counter width $clog2(PRESCALE), minimum 1; PRESCALE = 1 yields `step` = `en`
- The top level holds the FSM, the `led` datapath, and the flags.

## Test plan
- **UP_HALT:** WIDTH=8, PRESCALE=1, A=3, `en`=1. Expect `led` 0,1,2,3 on successive edges after LOAD. `H` rises with `led`=3 and holds for 50 cycles.
- **DOWN_HALT with pause:** PRESCALE=4, A=2. Expect `led` 2→1→0 at 4-cycle spacing, with `H` at 0. Dropping `en` for 6 cycles mid-interval delays the next step by exactly 6 cycles.
- **Empty span:** A=0 in UP_HALT. Expect `H`=1 on the LOAD edge with `led`=0. In PING_PONG with A=0, `led` stays 0 and `wrap` pulses every step.
- **UP_WRAP full range:** A=8'hFF, PRESCALE=1. After 256 steps, `led` 8'hFF→0 with a single `wrap` pulse; `H` stays 0.
- **PING_PONG:** A=2. Expect the sequence 0,1,2,1,0,1. `wrap` pulses at `led`=2 and at the return to 0; `dir` toggles at those points.
- **Reset mid-run and re-latch:** assert `Reset` at `led`=5 during an A=9 count. Expect all outputs 0 next cycle. Changing A to 4 before release gives a count to 4. Changing A during RUN has no effect.

Source files
------------

// File: rtl/ec_pkg.sv
// Shared types for the EC sequence counter: count modes and controller states.
package ec_pkg;

    typedef enum logic [1:0] {
        UP_HALT   = 2'b00,
        DOWN_HALT = 2'b01,
        UP_WRAP   = 2'b10,
        PING_PONG = 2'b11
    } ec_mode_t;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } ec_state_t;

    // Halt modes finish with H set; the other two run until reset.
    function automatic logic is_halt_mode(input ec_mode_t m);
        return (m == UP_HALT) || (m == DOWN_HALT);
    endfunction

endpackage

// File: rtl/ec_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
// The phase is held while en is low; clr restarts the interval.
module ec_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    // With PRESCALE = 1 the counter is pinned at 0, so step simply follows en.
    assign at_last = (cnt_q == LAST);
    assign step    = en && !clr && at_last;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ec_seq_counter.sv
// Target counter: latches A and mode after reset, steps led toward A at a prescaled rate,
// and reports completion (H), end-of-span turnarounds (wrap) and direction (dir).
module ec_seq_counter
    import ec_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] led,
    output logic             H,
    output logic             wrap,
    output logic             dir
);

    ec_state_t        state_q, state_d;
    ec_mode_t         mode_q, mode_d;
    ec_mode_t         mode_in;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             h_q, h_d;
    logic             wrap_q, wrap_d;
    logic             dir_q, dir_d;

    logic             step;
    logic             presc_en;
    logic             presc_clr;
    logic [WIDTH-1:0] led_inc;
    logic [WIDTH-1:0] led_dec;
    logic             halt_hit;

    assign mode_in = ec_mode_t'(mode);
    assign led_inc = led_q + WIDTH'(1);
    assign led_dec = led_q - WIDTH'(1);

    // Never wraps arithmetically: led stays within 0..tgt in every mode.
    assign halt_hit = ((mode_q == UP_HALT)   && (led_inc == tgt_q)) ||
                      ((mode_q == DOWN_HALT) && (led_dec == '0));

    assign presc_en  = en && (state_q == ST_RUN);
    assign presc_clr = (state_q == ST_LOAD);

    ec_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .Reset (Reset),
        .en    (presc_en),
        .clr   (presc_clr),
        .step  (step)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: state_d = (is_halt_mode(mode_in) && (A == '0)) ? ST_HALT : ST_RUN;
            ST_RUN:  if (step && halt_hit) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_LOAD;
        endcase
    end

    // Datapath: value, latched configuration and flags advance together on a step.
    always_comb begin
        tgt_d  = tgt_q;
        mode_d = mode_q;
        led_d  = led_q;
        h_d    = h_q;
        wrap_d = 1'b0;
        dir_d  = dir_q;
        case (state_q)
            ST_LOAD: begin
                tgt_d  = A;
                mode_d = mode_in;
                led_d  = (mode_in == DOWN_HALT) ? A : '0;
                dir_d  = (mode_in == DOWN_HALT);
                h_d    = is_halt_mode(mode_in) && (A == '0);
            end
            ST_RUN: begin
                if (step) begin
                    case (mode_q)
                        UP_HALT: begin
                            led_d = led_inc;
                            h_d   = halt_hit;
                        end
                        DOWN_HALT: begin
                            led_d = led_dec;
                            h_d   = halt_hit;
                        end
                        UP_WRAP: begin
                            if (led_q == tgt_q) begin
                                led_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_inc;
                            end
                        end
                        PING_PONG: begin
                            if (tgt_q == '0) begin
                                wrap_d = 1'b1;
                            end else if (!dir_q) begin
                                led_d = led_inc;
                                if (led_inc == tgt_q) begin
                                    dir_d  = 1'b1;
                                    wrap_d = 1'b1;
                                end
                            end else begin
                                led_d = led_dec;
                                if (led_dec == '0) begin
                                    dir_d  = 1'b0;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                        default: led_d = led_q;
                    endcase
                end
            end
            default: led_d = led_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            tgt_q  <= '0;
            mode_q <= UP_HALT;
            led_q  <= '0;
            h_q    <= 1'b0;
            wrap_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            h_q    <= h_d;
            wrap_q <= wrap_d;
            dir_q  <= dir_d;
        end
    end

    always_comb begin
        led  = led_q;
        H    = h_q;
        wrap = wrap_q;
        dir  = dir_q;
    end

endmodule

// File: tb/tb_ec_seq_counter.sv
// Directed bench for ec_seq_counter: one PRESCALE=1 and one PRESCALE=4 instance share stimulus.
module tb_ec_seq_counter;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] A;
    logic [1:0] mode;
    logic       en;

    logic [7:0] led1, led4;
    logic       h1, h4, w1, w4, d1, d4;

    int total = 0;
    int bad   = 0;

    int pp_led  [6] = '{1, 2, 1, 0, 1, 2};
    int pp_wrap [6] = '{0, 1, 0, 1, 0, 1};
    int pp_dir  [6] = '{0, 1, 1, 0, 0, 1};

    always #5 clk = ~clk;

    ec_seq_counter #(.WIDTH(8), .PRESCALE(1)) u_p1 (
        .clk   (clk),
        .Reset (Reset),
        .A     (A),
        .mode  (mode),
        .en    (en),
        .led   (led1),
        .H     (h1),
        .wrap  (w1),
        .dir   (d1)
    );

    ec_seq_counter #(.WIDTH(8), .PRESCALE(4)) u_p4 (
        .clk   (clk),
        .Reset (Reset),
        .A     (A),
        .mode  (mode),
        .en    (en),
        .led   (led4),
        .H     (h4),
        .wrap  (w4),
        .dir   (d4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One reset edge with the new A/mode applied; the following edge is the LOAD edge.
    task automatic restart(input logic [7:0] a, input logic [1:0] m);
        Reset = 1'b1;
        A     = a;
        mode  = m;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        en    = 1'b1;
        A     = 8'd3;
        mode  = 2'b00;
        tick();
        tick();

        check("rst_led1", led1, 0);
        check("rst_h1",   h1,   0);
        check("rst_w1",   w1,   0);
        check("rst_d1",   d1,   0);
        check("rst_led4", led4, 0);
        check("rst_h4",   h4,   0);
        check("rst_w4",   w4,   0);
        check("rst_d4",   d4,   0);

        // UP_HALT, A=3
        Reset = 1'b0;
        tick();
        check("uh_load_led1", led1, 0);
        check("uh_load_h1",   h1,   0);
        check("uh_load_led4", led4, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("uh_led1", led1, i);
            check("uh_h1",   h1,   (i == 3) ? 1 : 0);
            check("uh_led4", led4, 0);
        end
        for (int j = 1; j <= 50; j++) begin
            tick();
            check("uh_hold_led1", led1, 3);
            check("uh_hold_h1",   h1,   1);
            check("uh_p4_led4",   led4, ((3 + j) / 4 > 3) ? 3 : (3 + j) / 4);
            check("uh_p4_h4",     h4,   ((3 + j) >= 12) ? 1 : 0);
        end

        // DOWN_HALT, A=2, with a 6-cycle pause on the PRESCALE=4 instance
        restart(8'd2, 2'b01);
        tick();
        check("dh_load_led4", led4, 2);
        check("dh_load_dir4", d4,   1);
        check("dh_load_h4",   h4,   0);
        check("dh_load_led1", led1, 2);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("dh_wait_led4", led4, 2);
            check("dh_led1", led1, (i == 1) ? 1 : 0);
            check("dh_h1",   h1,   (i == 1) ? 0 : 1);
        end
        tick();
        check("dh_step1_led4", led4, 1);
        check("dh_step1_h4",   h4,   0);
        tick();
        tick();
        check("dh_mid_led4", led4, 1);
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("dh_pause_led4", led4, 1);
        end
        en = 1'b1;
        tick();
        check("dh_resume_led4", led4, 1);
        check("dh_resume_h4",   h4,   0);
        tick();
        check("dh_end_led4", led4, 0);
        check("dh_end_h4",   h4,   1);
        check("dh_end_dir4", d4,   1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dh_halt_off_led4", led4, 0);
            check("dh_halt_off_h4",   h4,   1);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dh_halt_on_led4", led4, 0);
            check("dh_halt_on_h4",   h4,   1);
        end

        // Empty span in both halt modes
        restart(8'd0, 2'b00);
        tick();
        check("es_uh_h1",   h1,   1);
        check("es_uh_led1", led1, 0);
        check("es_uh_h4",   h4,   1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("es_uh_hold_h1",   h1,   1);
            check("es_uh_hold_led1", led1, 0);
        end
        restart(8'd0, 2'b01);
        tick();
        check("es_dh_h4",   h4,   1);
        check("es_dh_led4", led4, 0);

        // PING_PONG with A=0: wrap on every step
        restart(8'd0, 2'b11);
        tick();
        check("pp0_load_led1", led1, 0);
        check("pp0_load_w1",   w1,   0);
        check("pp0_load_h1",   h1,   0);
        check("pp0_load_w4",   w4,   0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("pp0_led1", led1, 0);
            check("pp0_w1",   w1,   1);
            check("pp0_h1",   h1,   0);
            check("pp0_led4", led4, 0);
            check("pp0_w4",   w4,   ((i % 4) == 3) ? 1 : 0);
        end

        // UP_WRAP over the full 8-bit range
        restart(8'hFF, 2'b10);
        tick();
        check("uw_load_led1", led1, 0);
        for (int i = 1; i <= 255; i++) begin
            tick();
            check("uw_led1", led1, i);
            check("uw_w1",   w1,   0);
        end
        tick();
        check("uw_turn_led1", led1, 0);
        check("uw_turn_w1",   w1,   1);
        check("uw_turn_h1",   h1,   0);
        tick();
        check("uw_after_led1", led1, 1);
        check("uw_after_w1",   w1,   0);
        check("uw_after_h1",   h1,   0);
        check("uw_p4_led4",    led4, 64);

        // PING_PONG, A=2
        restart(8'd2, 2'b11);
        tick();
        check("pp_load_led1", led1, 0);
        check("pp_load_dir1", d1,   0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pp_led1",  led1, pp_led[i]);
            check("pp_wrap1", w1,   pp_wrap[i]);
            check("pp_dir1",  d1,   pp_dir[i]);
        end

        // Reset while wrap and dir are both high
        Reset = 1'b1;
        tick();
        check("rr_led1",  led1, 0);
        check("rr_wrap1", w1,   0);
        check("rr_dir1",  d1,   0);

        // Reset mid-run at led=5 of an A=9 count, re-latch A=4
        restart(8'd9, 2'b00);
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("rm_up_led1", led1, i);
        end
        Reset = 1'b1;
        A     = 8'd4;
        tick();
        check("rm_rst_led1", led1, 0);
        check("rm_rst_h1",   h1,   0);
        check("rm_rst_w1",   w1,   0);
        check("rm_rst_d1",   d1,   0);
        check("rm_rst_led4", led4, 0);
        check("rm_rst_h4",   h4,   0);
        Reset = 1'b0;
        tick();
        check("rm_load_led1", led1, 0);
        A    = 8'd9;
        mode = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("rm_led1", led1, i);
            check("rm_h1",   h1,   (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rm_hold_led1", led1, 4);
            check("rm_hold_h1",   h1,   1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
